hmm_step_sched: RTL

- Sequencer for the combinational 4-state HMM score datapath (four 4-term MAC engines feeding a max tree).
- For each symbol in an observation stream:
  - fetches the emission column bk1..bk4 from an external 1-cycle-latency emission RAM;
  - drives that column onto the datapath and holds it for a fixed multicycle settle window;
  - captures the 64-bit max and emits it on a valid/ready result port.
- Tracks the best score and its step index over the whole sequence.

---
 rtl/hmm_sched_pkg.sv | 28 ++
 rtl/hmm_step_sched_sat_cnt32.sv | 36 +++
 rtl/hmm_step_sched.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/hmm_sched_pkg.sv
// ---------------------------------------------------------------------------
// hmm_sched_pkg
// Shared types and constants for the HMM step scheduler.
//   state_t      : sequencer states
//   EM_W         : width of one emission column {bk4,bk3,bk2,bk1}
//   LANE_W       : width of one bk lane
//   BKn_LSB      : bit offset of lane bkn inside an emission column
// ---------------------------------------------------------------------------
package hmm_sched_pkg;

   localparam int EM_W    = 128;
   localparam int LANE_W  = 32;
   localparam int BK1_LSB = 0;
   localparam int BK2_LSB = 32;
   localparam int BK3_LSB = 64;
   localparam int BK4_LSB = 96;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_OBS    = 3'd1,
      ST_EMRD   = 3'd2,
      ST_EMWT   = 3'd3,
      ST_SETTLE = 3'd4,
      ST_OUT    = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

endpackage

// File: rtl/hmm_step_sched_sat_cnt32.sv
// ---------------------------------------------------------------------------
// sat_cnt32
// 32-bit saturating event counter used for stall accounting.
// Only present when HMM_STEP_SCHED_PERF_EN is defined.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   i_clr  : synchronous clear
//   i_inc  : count one event this cycle
//   o_cnt  : current count, sticks at 2^32-1
// ---------------------------------------------------------------------------
`ifdef HMM_STEP_SCHED_PERF_EN
module sat_cnt32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clr,
   input  logic        i_inc,
   output logic [31:0] o_cnt
);

   logic [31:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != 32'hFFFF_FFFF)) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/hmm_step_sched.sv
// ---------------------------------------------------------------------------
// hmm_step_sched
// Sequencer for the combinational 4-state HMM score datapath. For every
// observation symbol it reads the emission column from a 1-cycle-latency
// RAM, holds it on dp_bk for SETTLE_CYC cycles, captures dp_max and
// returns it on a valid/ready result port while tracking the best score.
//
// Parameters:
//   SETTLE_CYC : datapath settle window in cycles (1..255)
//   SYMW       : observation symbol width (RAM has 2^SYMW rows)
//   IDXW       : step counter / index width
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, num_obs        : sequence launch and length
//   busy, done            : sequence status
//   obs_valid/ready/sym   : observation stream
//   em_rd, em_addr        : emission RAM read request
//   em_data               : emission RAM read data (cycle after em_rd)
//   dp_bk                 : registered column driven to the datapath
//   dp_max                : datapath max result
//   res_valid/ready/data/idx : per-step result port
//   best_max, best_idx    : running best score and its step index
//   perf_stall            : stall cycle counter (HMM_STEP_SCHED_PERF_EN only)
//
// Optional feature macro: HMM_STEP_SCHED_PERF_EN
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_OBS    | obs_ready high, waiting for a symbol
// ST_EMRD   | em_rd strobe for the latched symbol
// ST_EMWT   | emission data arrives, loaded into dp_bk
// ST_SETTLE | dp_bk held while the datapath settles; sample dp_max at cnt==0
// ST_OUT    | res_valid high until res_ready
// ST_DONE   | one-cycle done pulse
// ---------------------------------------------------------------------------
module hmm_step_sched
   import hmm_sched_pkg::*;
#(
   parameter int SETTLE_CYC = 4,
   parameter int SYMW       = 2,
   parameter int IDXW       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDXW-1:0]  num_obs,
   output logic             busy,
   output logic             done,
   input  logic             obs_valid,
   output logic             obs_ready,
   input  logic [SYMW-1:0]  obs_sym,
   output logic             em_rd,
   output logic [SYMW-1:0]  em_addr,
   input  logic [EM_W-1:0]  em_data,
   output logic [EM_W-1:0]  dp_bk,
   input  logic [63:0]      dp_max,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [63:0]      res_data,
   output logic [IDXW-1:0]  res_idx,
   output logic [63:0]      best_max,
   output logic [IDXW-1:0]  best_idx
`ifdef HMM_STEP_SCHED_PERF_EN
   ,
   output logic [31:0]      perf_stall
`endif
);

   localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYC - 1);

   state_t            r_state;
   logic [IDXW-1:0]   r_num_obs;
   logic [IDXW-1:0]   r_step;
   logic [7:0]        r_cnt;
   logic              r_busy;
   logic              r_done;
   logic              r_obs_ready;
   logic              r_em_rd;
   logic [SYMW-1:0]   r_em_addr;
   logic [EM_W-1:0]   r_dp_bk;
   logic              r_res_valid;
   logic [63:0]       r_res_data;
   logic [IDXW-1:0]   r_res_idx;
   logic [63:0]       r_best_max;
   logic [IDXW-1:0]   r_best_idx;

   logic [IDXW-1:0]   w_step_inc;

   assign w_step_inc = r_step + {{(IDXW-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_num_obs   <= '0;
         r_step      <= '0;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_obs_ready <= 1'b0;
         r_em_rd     <= 1'b0;
         r_em_addr   <= '0;
         r_dp_bk     <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_idx   <= '0;
         r_best_max  <= '0;
         r_best_idx  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_num_obs  <= num_obs;
                  r_step     <= '0;
                  r_best_max <= '0;
                  r_best_idx <= '0;
                  r_busy     <= 1'b1;
                  if (num_obs == '0) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_obs_ready <= 1'b1;
                     r_state     <= ST_OBS;
                  end
               end
            end
            ST_OBS: begin
               // em_addr doubles as the latched symbol for this step
               if (obs_valid) begin
                  r_em_addr   <= obs_sym;
                  r_obs_ready <= 1'b0;
                  r_em_rd     <= 1'b1;
                  r_state     <= ST_EMRD;
               end
            end
            ST_EMRD: begin
               r_em_rd <= 1'b0;
               r_state <= ST_EMWT;
            end
            ST_EMWT: begin
               r_dp_bk[BK1_LSB +: LANE_W] <= em_data[BK1_LSB +: LANE_W];
               r_dp_bk[BK2_LSB +: LANE_W] <= em_data[BK2_LSB +: LANE_W];
               r_dp_bk[BK3_LSB +: LANE_W] <= em_data[BK3_LSB +: LANE_W];
               r_dp_bk[BK4_LSB +: LANE_W] <= em_data[BK4_LSB +: LANE_W];
               r_cnt   <= CNT_LOAD;
               r_state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (r_cnt == 8'd0) begin
                  r_res_data  <= dp_max;
                  r_res_idx   <= r_step;
                  r_res_valid <= 1'b1;
                  // strict compare keeps the earliest index on ties
                  if ((dp_max > r_best_max) || (r_step == '0)) begin
                     r_best_max <= dp_max;
                     r_best_idx <= r_step;
                  end
                  r_state <= ST_OUT;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            ST_OUT: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_step      <= w_step_inc;
                  if (w_step_inc == r_num_obs) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_obs_ready <= 1'b1;
                     r_state     <= ST_OBS;
                  end
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign obs_ready = r_obs_ready;
   assign em_rd     = r_em_rd;
   assign em_addr   = r_em_addr;
   assign dp_bk     = r_dp_bk;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_idx   = r_res_idx;
   assign best_max  = r_best_max;
   assign best_idx  = r_best_idx;

`ifdef HMM_STEP_SCHED_PERF_EN
   logic w_perf_clr;
   logic w_perf_inc;

   assign w_perf_clr = (r_state == ST_IDLE) && start;
   assign w_perf_inc = ((r_state == ST_OBS) && !obs_valid) ||
                       ((r_state == ST_OUT) && !res_ready);

   sat_cnt32 u_perf (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_perf_clr),
      .i_inc (w_perf_inc),
      .o_cnt (perf_stall)
   );
`endif

endmodule
